// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshakes on both sides and an iterative
// shift-add multiply that occupies the block for WIDTH cycles.
module alu_pipe #(
  parameter int WIDTH  = 8,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  input  logic [2:0]       operation,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_n,
  output logic             flag_v,
  output logic             illegal
);

  localparam int MSB = WIDTH - 1;
  localparam int CW  = $clog2(WIDTH);

  typedef enum logic {IDLE, MUL} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] a_sh;
  logic [WIDTH-1:0]   b_sh;

  logic               accept;
  logic               is_mul;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [WIDTH-1:0]   s_res;
  logic               s_c;
  logic               s_v;
  logic               s_ill;
  logic [2*WIDTH-1:0] next_acc;
  logic               last_step;

  // in_ready is held low during reset so nothing is accepted across release
  always_comb begin
    in_ready = !rst && (state == IDLE) && (!out_valid || out_ready);
    accept   = in_valid && in_ready;
    is_mul   = (operation == 3'b111) && MUL_EN;
  end

  always_comb begin
    sum   = {1'b0, operand1} + {1'b0, operand2};
    diff  = {1'b0, operand1} - {1'b0, operand2};
    s_res = '0;
    s_c   = 1'b0;
    s_v   = 1'b0;
    s_ill = 1'b0;
    case (operation)
      3'b000: begin
        s_res = sum[WIDTH-1:0];
        s_c   = sum[WIDTH];
        s_v   = (operand1[MSB] == operand2[MSB]) && (sum[MSB] != operand1[MSB]);
      end
      3'b001: begin
        s_res = diff[WIDTH-1:0];
        s_c   = diff[WIDTH];
        s_v   = (operand1[MSB] != operand2[MSB]) && (diff[MSB] != operand1[MSB]);
      end
      3'b010: s_res = operand1 & operand2;
      3'b011: s_res = operand1 | operand2;
      3'b100: s_res = operand1 ^ operand2;
      3'b101: s_res = ~operand1;
      3'b110: begin
        s_res = {operand1[WIDTH-2:0], 1'b0};
        s_c   = operand1[MSB];
      end
      default: s_ill = 1'b1;
    endcase
  end

  always_comb begin
    next_acc  = acc + (b_sh[0] ? a_sh : '0);
    last_step = (cnt == CW'(WIDTH - 1));
  end

  // Output registers only change when a new result loads, which gives the
  // hold-under-backpressure behaviour for free
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      flag_z    <= 1'b0;
      flag_c    <= 1'b0;
      flag_n    <= 1'b0;
      flag_v    <= 1'b0;
      illegal   <= 1'b0;
      cnt       <= '0;
      acc       <= '0;
      a_sh      <= '0;
      b_sh      <= '0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (is_mul) begin
              a_sh  <= {{WIDTH{1'b0}}, operand1};
              b_sh  <= operand2;
              acc   <= '0;
              cnt   <= '0;
              state <= MUL;
            end else begin
              result    <= s_res;
              flag_z    <= (s_res == '0);
              flag_c    <= s_c;
              flag_n    <= s_res[MSB];
              flag_v    <= s_v;
              illegal   <= s_ill;
              out_valid <= 1'b1;
            end
          end
        end
        MUL: begin
          acc  <= next_acc;
          a_sh <= a_sh << 1;
          b_sh <= b_sh >> 1;
          cnt  <= cnt + CW'(1);
          if (last_step) begin
            result    <= next_acc[WIDTH-1:0];
            flag_z    <= (next_acc[WIDTH-1:0] == '0);
            flag_c    <= |next_acc[2*WIDTH-1:WIDTH];
            flag_n    <= next_acc[MSB];
            flag_v    <= 1'b0;
            illegal   <= 1'b0;
            out_valid <= 1'b1;
            cnt       <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: table of single-cycle ops plus hand-written
// multiply, backpressure, reset-mid-multiply and MUL_EN=0 sequences.
module tb_alu_pipe;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] operand1;
  logic [7:0] operand2;
  logic [2:0] operation;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic       flag_z, flag_c, flag_n, flag_v, illegal;

  logic       nm_in_valid;
  logic       nm_in_ready;
  logic [7:0] nm_operand1;
  logic [7:0] nm_operand2;
  logic [2:0] nm_operation;
  logic       nm_out_valid;
  logic       nm_out_ready;
  logic [7:0] nm_result;
  logic       nm_z, nm_c, nm_n, nm_v, nm_illegal;

  int compared;
  int mismatched;

  alu_pipe #(.WIDTH(8), .MUL_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .operand1(operand1), .operand2(operand2), .operation(operation),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flag_z(flag_z), .flag_c(flag_c),
    .flag_n(flag_n), .flag_v(flag_v), .illegal(illegal)
  );

  alu_pipe #(.WIDTH(8), .MUL_EN(1'b0)) dut_nm (
    .clk(clk), .rst(rst),
    .in_valid(nm_in_valid), .in_ready(nm_in_ready),
    .operand1(nm_operand1), .operand2(nm_operand2), .operation(nm_operation),
    .out_valid(nm_out_valid), .out_ready(nm_out_ready),
    .result(nm_result), .flag_z(nm_z), .flag_c(nm_c),
    .flag_n(nm_n), .flag_v(nm_v), .illegal(nm_illegal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic [3:0] zcnv;
  } vec_t;

  localparam int NVEC = 13;
  vec_t vecs[NVEC];

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    operation = op;
    operand1  = a;
    operand2  = b;
    in_valid  = 1'b1;
  endtask

  // Multiply: out_valid must appear exactly 9 cycles after acceptance
  task automatic doMul(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] exp_res, input logic [3:0] exp_f);
    @(negedge clk);
    applyStimulus(3'b111, a, b);
    checkOutput("mul_accept_ready", 16'(in_ready), 16'h1);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      checkOutput($sformatf("mul_busy_ready_c%0d", k), 16'(in_ready), 16'h0);
      checkOutput($sformatf("mul_busy_valid_c%0d", k), 16'(out_valid), 16'h0);
    end
    @(negedge clk);
    checkOutput("mul_valid_c9", 16'(out_valid), 16'h1);
    checkOutput("mul_result", 16'(result), 16'(exp_res));
    checkOutput("mul_flags", 16'({flag_z, flag_c, flag_n, flag_v}), 16'(exp_f));
    checkOutput("mul_illegal", 16'(illegal), 16'h0);
  endtask

  initial begin
    bit saw_valid;
    compared   = 0;
    mismatched = 0;
    rst        = 1'b1;
    in_valid   = 1'b0;
    operand1   = '0;
    operand2   = '0;
    operation  = '0;
    out_ready  = 1'b1;
    nm_in_valid  = 1'b0;
    nm_operand1  = '0;
    nm_operand2  = '0;
    nm_operation = '0;
    nm_out_ready = 1'b1;

    //              op      A      B      R      ZCNV
    vecs[0]  = '{3'b000, 8'h0D, 8'h03, 8'h10, 4'b0000};
    vecs[1]  = '{3'b001, 8'h0D, 8'h03, 8'h0A, 4'b0000};
    vecs[2]  = '{3'b010, 8'h0D, 8'h03, 8'h01, 4'b0000};
    vecs[3]  = '{3'b011, 8'h0D, 8'h03, 8'h0F, 4'b0000};
    vecs[4]  = '{3'b100, 8'h0D, 8'h03, 8'h0E, 4'b0000};
    vecs[5]  = '{3'b101, 8'h0D, 8'h03, 8'hF2, 4'b0010};
    vecs[6]  = '{3'b110, 8'h0D, 8'h03, 8'h1A, 4'b0000};
    vecs[7]  = '{3'b000, 8'h7F, 8'h01, 8'h80, 4'b0011};
    vecs[8]  = '{3'b000, 8'hFF, 8'h01, 8'h00, 4'b1100};
    vecs[9]  = '{3'b001, 8'h03, 8'h0D, 8'hF6, 4'b0110};
    vecs[10] = '{3'b110, 8'h80, 8'h00, 8'h00, 4'b1100};
    vecs[11] = '{3'b001, 8'h80, 8'h01, 8'h7F, 4'b0001};
    vecs[12] = '{3'b010, 8'hF0, 8'h0F, 8'h00, 4'b1000};

    @(negedge clk);
    checkOutput("rst_out_valid", 16'(out_valid), 16'h0);
    checkOutput("rst_result", 16'(result), 16'h0);
    checkOutput("rst_flags", 16'({flag_z, flag_c, flag_n, flag_v, illegal}), 16'h0);
    checkOutput("rst_in_ready", 16'(in_ready), 16'h0);
    rst = 1'b0;

    // Back-to-back single-cycle ops: result of vector i-1 checked while i is driven
    for (int i = 0; i <= NVEC; i++) begin
      @(negedge clk);
      if (i > 0) begin
        checkOutput($sformatf("vec%0d_valid", i-1), 16'(out_valid), 16'h1);
        checkOutput($sformatf("vec%0d_result", i-1), 16'(result), 16'(vecs[i-1].res));
        checkOutput($sformatf("vec%0d_zcnv", i-1),
                    16'({flag_z, flag_c, flag_n, flag_v}), 16'(vecs[i-1].zcnv));
        checkOutput($sformatf("vec%0d_illegal", i-1), 16'(illegal), 16'h0);
      end
      if (i < NVEC) begin
        applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b);
        checkOutput($sformatf("vec%0d_in_ready", i), 16'(in_ready), 16'h1);
      end else begin
        in_valid = 1'b0;
      end
    end

    doMul(8'h0D, 8'h03, 8'h27, 4'b0000);
    doMul(8'h10, 8'h10, 8'h00, 4'b1100);

    // Backpressure: result held for 5 cycles while a new op waits
    @(negedge clk);
    out_ready = 1'b0;
    applyStimulus(3'b000, 8'h7F, 8'h01);
    checkOutput("bp_accept_ready", 16'(in_ready), 16'h1);
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      applyStimulus(3'b000, 8'h01, 8'h01);
      checkOutput($sformatf("bp_valid_%0d", j), 16'(out_valid), 16'h1);
      checkOutput($sformatf("bp_result_%0d", j), 16'(result), 16'h80);
      checkOutput($sformatf("bp_flags_%0d", j), 16'({flag_z, flag_c, flag_n, flag_v}), 16'b0011);
      checkOutput($sformatf("bp_in_ready_%0d", j), 16'(in_ready), 16'h0);
    end
    @(negedge clk);
    checkOutput("bp_still_held", 16'(result), 16'h80);
    out_ready = 1'b1;
    #1;
    checkOutput("bp_release_ready", 16'(in_ready), 16'h1);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("bp_next_valid", 16'(out_valid), 16'h1);
    checkOutput("bp_next_result", 16'(result), 16'h02);

    // Asynchronous reset during cycle 4 of a multiply
    @(negedge clk);
    applyStimulus(3'b111, 8'h0D, 8'h03);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    checkOutput("pre_rst_result", 16'(result), 16'h02);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst_valid", 16'(out_valid), 16'h0);
    checkOutput("async_rst_result", 16'(result), 16'h0);
    checkOutput("async_rst_ready", 16'(in_ready), 16'h0);
    @(negedge clk);
    rst = 1'b0;
    saw_valid = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (out_valid) saw_valid = 1'b1;
    end
    checkOutput("no_valid_after_abort", 16'(saw_valid), 16'h0);
    applyStimulus(3'b000, 8'h01, 8'h01);
    checkOutput("post_rst_ready", 16'(in_ready), 16'h1);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("post_rst_valid", 16'(out_valid), 16'h1);
    checkOutput("post_rst_result", 16'(result), 16'h02);

    // MUL_EN=0 build: opcode 111 is illegal with latency 1
    @(negedge clk);
    nm_operation = 3'b111;
    nm_operand1  = 8'h05;
    nm_operand2  = 8'h05;
    nm_in_valid  = 1'b1;
    checkOutput("nm_accept_ready", 16'(nm_in_ready), 16'h1);
    @(negedge clk);
    checkOutput("nm_ill_valid", 16'(nm_out_valid), 16'h1);
    checkOutput("nm_ill_result", 16'(nm_result), 16'h00);
    checkOutput("nm_ill_flags", 16'({nm_z, nm_c, nm_n, nm_v}), 16'b1000);
    checkOutput("nm_ill_flag", 16'(nm_illegal), 16'h1);
    nm_operation = 3'b000;
    nm_operand1  = 8'h01;
    nm_operand2  = 8'h02;
    @(negedge clk);
    nm_in_valid = 1'b0;
    checkOutput("nm_add_valid", 16'(nm_out_valid), 16'h1);
    checkOutput("nm_add_result", 16'(nm_result), 16'h03);
    checkOutput("nm_add_illegal", 16'(nm_illegal), 16'h0);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
